// File: rtl/tap_transposed_mc.sv
// ---------------------------------------------------------------------------
// tap_transposed_mc
//   One tap of a transposed-form FIR whose state is shared by NUM_CH
//   time-interleaved channels. Each valid sample adds its scaled product,
//   din * weight in Q1.(DATA_WIDTH-1), to the upstream partial sum. The
//   result is stored in the partial-sum register of that channel.
//
//   Optional feature: define TAP_TRANSPOSED_SAT_EN to saturate the scaled
//   product and the sum. The default build uses two's-complement wrap.
//   The overflow flags report in both builds.
//
// Parameters
//   DATA_WIDTH : width of samples, weights and sums (Q1.(DATA_WIDTH-1))
//   NUM_CH     : number of interleaved channels (1..16)
//   ROUND      : 0 = truncate toward -inf, 1 = round half up
//
// Ports
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : global enable; all state holds while low
//   i_valid, iv_ch : sample strobe and its channel index
//   iv_din         : sample; also passed to ov_dout combinationally
//   iv_weight      : tap coefficient
//   iv_sum         : upstream partial sum
//   i_flush        : clear all partial sums; a sample in the same cycle is dropped
//   i_clr_flags    : clear sticky flags; a new overflow in the same cycle wins
//   ov_sum         : stored partial sum of channel iv_ch (0 if out of range)
//   o_prod_ovf     : sticky flag; scaled product fell outside the DATA_WIDTH range
//   o_sum_ovf      : sticky flag; sum fell outside the DATA_WIDTH range
// ---------------------------------------------------------------------------
module tap_transposed_mc #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_CH     = 4,
  parameter int ROUND      = 0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic                         i_valid,
  input  logic [CH_W-1:0]              iv_ch,
  input  logic signed [DATA_WIDTH-1:0] iv_din,
  input  logic signed [DATA_WIDTH-1:0] iv_weight,
  input  logic signed [DATA_WIDTH-1:0] iv_sum,
  input  logic                         i_flush,
  input  logic                         i_clr_flags,
  output logic signed [DATA_WIDTH-1:0] ov_sum,
  output logic signed [DATA_WIDTH-1:0] ov_dout,
  output logic                         o_prod_ovf,
  output logic                         o_sum_ovf
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * W;   // full product width
  localparam int SW = W + 2;   // width of the scaled product and the sum

  // DATA_WIDTH range limits, sign-extended to SW bits for the overflow compares
  localparam logic signed [SW-1:0] MAX_S  = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_S  = {3'b111, {(W-1){1'b0}}};
  localparam logic signed [PW-1:0] HALF_P = PW'(1) << (W-2);

  logic signed [PW-1:0] prod_w;
  logic signed [PW-1:0] prod_r;
  logic signed [SW-1:0] ps;
  logic signed [W-1:0]  ps_lim;
  logic signed [SW-1:0] s;
  logic signed [W-1:0]  sum_d;
  logic                 prod_ovf;
  logic                 sum_ovf;
  logic                 ch_ok;
  logic                 wr_en;
  logic                 prod_ovf_d;
  logic                 sum_ovf_d;

  logic [NUM_CH-1:0][W-1:0] sum_q;
  logic                     prod_ovf_q;
  logic                     sum_ovf_q;

  // Full-precision signed product
  assign prod_w = $signed({{W{iv_din[W-1]}}, iv_din}) *
                  $signed({{W{iv_weight[W-1]}}, iv_weight});

  generate
    if (ROUND != 0) begin : g_rnd
      // Adding half an LSB before the floor shift gives round half up.
      // |prod| <= 2^(2W-2), so this add cannot overflow PW bits.
      assign prod_r = prod_w + HALF_P;
    end else begin : g_trunc
      assign prod_r = prod_w;
    end
  endgenerate

  // The arithmetic shift floors toward -inf. The result needs at most
  // W+1 bits, so truncating to SW bits is lossless.
  assign ps       = SW'(prod_r >>> (W-1));
  assign prod_ovf = (ps > MAX_S) || (ps < MIN_S);

`ifdef TAP_TRANSPOSED_SAT_EN
  localparam logic signed [W-1:0] MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};

  assign ps_lim = prod_ovf ? (ps[SW-1] ? MIN_W : MAX_W) : ps[W-1:0];
  assign s      = {{2{ps_lim[W-1]}}, ps_lim} + {{2{iv_sum[W-1]}}, iv_sum};
  assign sum_ovf = (s > MAX_S) || (s < MIN_S);
  assign sum_d  = sum_ovf ? (s[SW-1] ? MIN_W : MAX_W) : s[W-1:0];
`else
  assign ps_lim = ps[W-1:0];
  assign s      = {{2{ps_lim[W-1]}}, ps_lim} + {{2{iv_sum[W-1]}}, iv_sum};
  assign sum_ovf = (s > MAX_S) || (s < MIN_S);
  assign sum_d  = s[W-1:0];
`endif

  // Indices >= NUM_CH are possible when NUM_CH is not a power of two
  assign ch_ok = ({1'b0, iv_ch} < (CH_W+1)'(NUM_CH));
  // Flush wins over a write in the same cycle, and that sample is dropped
  assign wr_en = i_en && i_valid && ch_ok && !i_flush;

  // A new overflow takes precedence over a clear in the same cycle
  assign prod_ovf_d = (prod_ovf_q && !i_clr_flags) || (wr_en && prod_ovf);
  assign sum_ovf_d  = (sum_ovf_q  && !i_clr_flags) || (wr_en && sum_ovf);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_q      <= '0;
      prod_ovf_q <= 1'b0;
      sum_ovf_q  <= 1'b0;
    end else if (i_en) begin
      prod_ovf_q <= prod_ovf_d;
      sum_ovf_q  <= sum_ovf_d;
      if (i_flush) begin
        sum_q <= '0;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_en && (iv_ch == CH_W'(i))) sum_q[i] <= sum_d;
        end
      end
    end
  end

  // Read port; an out-of-range index reads 0
  always_comb begin
    ov_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (iv_ch == CH_W'(i)) ov_sum = sum_q[i];
    end
  end

  assign ov_dout    = iv_din;
  assign o_prod_ovf = prod_ovf_q;
  assign o_sum_ovf  = sum_ovf_q;

endmodule

// File: tb/tb_tap_transposed_mc.sv
// ---------------------------------------------------------------------------
// tb_tap_transposed_mc
//   Bench for tap_transposed_mc with DATA_WIDTH=8 and NUM_CH=4. Two
//   instances share the stimulus: one has ROUND=0 and one has ROUND=1.
//   The reference model works on plain integers and uses floor division,
//   range clamp or modular wrap, and a sum per channel.
// ---------------------------------------------------------------------------
module tb_tap_transposed_mc;
  localparam int W  = 8;
  localparam int NC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, valid, flush, clr;
  logic [1:0] ch;
  logic [7:0] din, wt, sm;
  logic [1:0][7:0] osum, odout;
  logic [1:0] opf, osf;

  tap_transposed_mc #(.DATA_WIDTH(W), .NUM_CH(NC), .ROUND(0)) u_r0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid), .iv_ch(ch),
    .iv_din(din), .iv_weight(wt), .iv_sum(sm), .i_flush(flush),
    .i_clr_flags(clr), .ov_sum(osum[0]), .ov_dout(odout[0]),
    .o_prod_ovf(opf[0]), .o_sum_ovf(osf[0]));

  tap_transposed_mc #(.DATA_WIDTH(W), .NUM_CH(NC), .ROUND(1)) u_r1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid), .iv_ch(ch),
    .iv_din(din), .iv_weight(wt), .iv_sum(sm), .i_flush(flush),
    .i_clr_flags(clr), .ov_sum(osum[1]), .ov_dout(odout[1]),
    .o_prod_ovf(opf[1]), .o_sum_ovf(osf[1]));

  int nvec = 0;
  int nerr = 0;

  // ---------------- reference model ----------------
  int msum [2][NC];
  bit mpf  [2];
  bit msf  [2];

  function automatic int floor_div(longint n, longint d);
    if (n >= 0) return int'(n / d);
    return int'(-((-n + d - 1) / d));
  endfunction

  function automatic bit out_of_range(int v);
    return (v > 127) || (v < -128);
  endfunction

  function automatic int fit(int v);
`ifdef TAP_TRANSPOSED_SAT_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`else
    int m;
    m = ((v % 256) + 256) % 256;
    return (m >= 128) ? m - 256 : m;
`endif
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NC; c++) msum[r][c] = 0;
      mpf[r] = 0;
      msf[r] = 0;
    end
  endfunction

  // Advances the model by one rising edge, using the current inputs
  function automatic void model_step();
    for (int r = 0; r < 2; r++) begin
      longint p;
      int ps, s;
      bit pfn, sfn;
      pfn = 0;
      sfn = 0;
      if (en) begin
        if (flush) begin
          for (int c = 0; c < NC; c++) msum[r][c] = 0;
        end else if (valid) begin
          p   = longint'($signed(din)) * longint'($signed(wt));
          ps  = floor_div(p + ((r == 1) ? 64 : 0), 128);
          pfn = out_of_range(ps);
          s   = fit(ps) + int'($signed(sm));
          sfn = out_of_range(s);
          msum[r][ch] = fit(s);
        end
        mpf[r] = (mpf[r] && !clr) || pfn;
        msf[r] = (msf[r] && !clr) || sfn;
      end
    end
  endfunction

  // ---------------- drive helpers ----------------
  task automatic drive(input logic e, input logic v, input logic [1:0] c,
                       input logic [7:0] d, input logic [7:0] w,
                       input logic [7:0] s, input logic f, input logic cl);
    en = e; valid = v; ch = c; din = d; wt = w; sm = s; flush = f; clr = cl;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [1:0] c);
    drive(1, 0, c, 8'h00, 8'h00, 8'h00, 0, 0);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    for (int c = 0; c < NC; c++) begin
      ch = 2'(c);
      #1;
      for (int r = 0; r < 2; r++) begin
        nvec++;
        if (osum[r] !== 8'h00) begin
          nerr++;
          $display("FAIL reset_sum r%0d ch%0d got %h want 00", r, c, osum[r]);
        end
      end
    end
    nvec++;
    if ({opf, osf} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_flags got pf=%b sf=%b want 00/00", opf, osf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    drive(1, 1, 0, 8'h40, 8'h40, 8'h00, 0, 0);
    #1;
    for (int r = 0; r < 2; r++) begin
      nvec++;
      if (odout[r] !== 8'h40) begin
        nerr++;
        $display("FAIL dout_pass r%0d got %h want 40", r, odout[r]);
      end
    end
    step();
    idle(0);
    for (int r = 0; r < 2; r++) begin
      nvec++;
      if (osum[r] !== 8'h20 || opf[r] !== 1'b0 || osf[r] !== 1'b0) begin
        nerr++;
        $display("FAIL basic_mac r%0d got %h pf=%b sf=%b want 20 0 0",
                 r, osum[r], opf[r], osf[r]);
      end
    end
  endtask

  task automatic test_prod_ovf();
    logic [7:0] e;
`ifdef TAP_TRANSPOSED_SAT_EN
    e = 8'h7F;
`else
    e = 8'h80;
`endif
    drive(1, 1, 1, 8'h80, 8'h80, 8'h00, 0, 0);
    step();
    idle(1);
    for (int r = 0; r < 2; r++) begin
      nvec++;
      if (osum[r] !== e || opf[r] !== 1'b1 || osf[r] !== 1'b0) begin
        nerr++;
        $display("FAIL prod_ovf r%0d got %h pf=%b sf=%b want %h 1 0",
                 r, osum[r], opf[r], osf[r], e);
      end
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    step();
  endtask

  task automatic test_sum_ovf();
    logic [7:0] e;
`ifdef TAP_TRANSPOSED_SAT_EN
    e = 8'h7F;
`else
    e = 8'hBF;   // 95 + 96 = 191, wraps to -65
`endif
    drive(1, 1, 2, 8'h60, 8'h7F, 8'h60, 0, 0);
    step();
    idle(2);
    for (int r = 0; r < 2; r++) begin
      nvec++;
      if (osum[r] !== e || osf[r] !== 1'b1 || opf[r] !== 1'b0) begin
        nerr++;
        $display("FAIL sum_ovf r%0d got %h pf=%b sf=%b want %h 0 1",
                 r, osum[r], opf[r], osf[r], e);
      end
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    step();
    nvec++;
    if ({opf, osf} !== 4'b0000) begin
      nerr++;
      $display("FAIL clr_flags got pf=%b sf=%b want 00/00", opf, osf);
    end
  endtask

  task automatic test_round();
    drive(1, 1, 3, 8'h01, 8'h40, 8'h00, 0, 0);
    step();
    idle(3);
    nvec++;
    if (osum[0] !== 8'h00) begin
      nerr++;
      $display("FAIL round_trunc got %h want 00", osum[0]);
    end
    nvec++;
    if (osum[1] !== 8'h01) begin
      nerr++;
      $display("FAIL round_half_up got %h want 01", osum[1]);
    end
  endtask

  task automatic test_interleave();
    logic [7:0] want [NC];
    want[0] = 8'h10; want[1] = 8'h20; want[2] = 8'h00; want[3] = 8'h30;
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    step();
    drive(1, 1, 0, 8'($urandom), 8'h00, 8'h10, 0, 0); step();
    drive(1, 1, 1, 8'($urandom), 8'h00, 8'h20, 0, 0); step();
    drive(1, 1, 3, 8'($urandom), 8'h00, 8'h30, 0, 0); step();
    for (int c = 0; c < NC; c++) begin
      idle(2'(c));
      for (int r = 0; r < 2; r++) begin
        nvec++;
        if (osum[r] !== want[c]) begin
          nerr++;
          $display("FAIL interleave r%0d ch%0d got %h want %h", r, c, osum[r], want[c]);
        end
      end
    end
  endtask

  task automatic test_enable_flags();
    logic [7:0] e;
    drive(1, 1, 0, 8'h80, 8'h80, 8'h00, 0, 0);
    step();
    e = 8'(msum[0][0]);
    // en low: the write, flush and clear are all ignored
    drive(0, 1, 0, 8'h40, 8'h40, 8'h00, 1, 1);
    step();
    idle(0);
    for (int r = 0; r < 2; r++) begin
      nvec++;
      if (osum[r] !== e || opf[r] !== 1'b1) begin
        nerr++;
        $display("FAIL en_hold r%0d got %h pf=%b want %h 1", r, osum[r], opf[r], e);
      end
    end
    // A new overflow in the same cycle as a clear keeps the flag set
    drive(1, 1, 1, 8'h80, 8'h80, 8'h00, 0, 1);
    step();
    nvec++;
    if (opf !== 2'b11) begin
      nerr++;
      $display("FAIL ovf_beats_clr got pf=%b want 11", opf);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    step();
    nvec++;
    if (opf !== 2'b00) begin
      nerr++;
      $display("FAIL clr_after got pf=%b want 00", opf);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(7) != 0), $urandom_range(1), 2'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(31) == 0), ($urandom_range(15) == 0));
      #1;
      for (int r = 0; r < 2; r++) begin
        nvec++;
        if (osum[r] !== 8'(msum[r][ch]) || opf[r] !== mpf[r] ||
            osf[r] !== msf[r] || odout[r] !== din) begin
          nerr++;
          $display("FAIL random n%0d r%0d ch%0d got %h pf=%b sf=%b want %h %b %b",
                   n, r, ch, osum[r], opf[r], osf[r], 8'(msum[r][ch]), mpf[r], msf[r]);
        end
      end
      step();
    end
  endtask

  task automatic test_flush_reset();
    for (int c = 0; c < NC; c++) begin
      drive(1, 1, 2'(c), 8'($urandom), 8'($urandom), 8'($urandom | 1), 0, 0);
      step();
    end
    // The flush drops the valid write in the same cycle
    drive(1, 1, 2, 8'h40, 8'h40, 8'h11, 1, 0);
    step();
    for (int c = 0; c < NC; c++) begin
      idle(2'(c));
      for (int r = 0; r < 2; r++) begin
        nvec++;
        if (osum[r] !== 8'h00) begin
          nerr++;
          $display("FAIL flush_drop r%0d ch%0d got %h want 00", r, c, osum[r]);
        end
      end
    end
    drive(1, 1, 0, 8'h80, 8'h80, 8'h10, 0, 0); step();
    drive(1, 1, 3, 8'h60, 8'h7F, 8'h60, 0, 0); step();
    drive(1, 1, 2, 8'h33, 8'h21, 8'h05, 0, 0);
    #2;
    rst_n = 1'b0;      // asynchronous, between clock edges, in mid-stream
    model_reset();
    #1;
    for (int c = 0; c < NC; c++) begin
      ch = 2'(c);
      #1;
      for (int r = 0; r < 2; r++) begin
        nvec++;
        if (osum[r] !== 8'h00) begin
          nerr++;
          $display("FAIL async_rst r%0d ch%0d got %h want 00", r, c, osum[r]);
        end
      end
    end
    nvec++;
    if ({opf, osf} !== 4'b0000) begin
      nerr++;
      $display("FAIL async_rst_flags got pf=%b sf=%b want 00/00", opf, osf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 1, 8'h40, 8'h40, 8'h05, 0, 0);
    step();
    idle(1);
    for (int r = 0; r < 2; r++) begin
      nvec++;
      if (osum[r] !== 8'h25 || opf[r] !== 1'b0 || osf[r] !== 1'b0) begin
        nerr++;
        $display("FAIL post_rst_write r%0d got %h pf=%b sf=%b want 25 0 0",
                 r, osum[r], opf[r], osf[r]);
      end
    end
    idle(0);
    nvec++;
    if (osum !== 16'h0000) begin
      nerr++;
      $display("FAIL post_rst_other got %h want 0000", osum);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prod_ovf();
    test_sum_ovf();
    test_round();
    test_interleave();
    test_enable_flags();
    test_random();
    test_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Run-length bound, in case the stimulus never completes
  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d want completion", nvec);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tap_transposed_mc.md
TAP_TRANSPOSED_MC -- requirements
Module: tap_transposed_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, which sets the width of samples, weights and sums (Q1.(DATA_WIDTH-1)).
REQ-002 SHALL have parameter NUM_CH, default 4, the number of time-interleaved channels (1..16).
REQ-003 SHALL have parameter ROUND, default 0: 0 = truncate toward minus infinity; 1 = round half up.
REQ-004 SHALL have port i_clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst_n, input, width 1: asynchronous, active-low reset.
REQ-006 SHALL have port i_en, input, width 1: global enable; when low, all state holds.
REQ-007 SHALL have port i_valid, input, width 1: a sample is present this cycle.
REQ-008 SHALL have port iv_ch, input, width clog2(NUM_CH) (minimum 1): channel index of the present sample.
REQ-009 SHALL have ports iv_din, iv_weight and iv_sum, each input, signed, DATA_WIDTH: the sample, the tap coefficient and the upstream partial sum.
REQ-010 SHALL have port i_flush, input, width 1: synchronous clear of all partial sums.
REQ-011 SHALL have port i_clr_flags, input, width 1: synchronous clear of the sticky flags.
REQ-012 SHALL have port ov_sum, output, signed, DATA_WIDTH: the stored partial sum of channel iv_ch.
REQ-013 SHALL have port ov_dout, output, signed, DATA_WIDTH: iv_din passed through combinationally.
REQ-014 SHALL have ports o_prod_ovf and o_sum_ovf, each output, width 1: sticky overflow flags.

Function
REQ-015 SHALL hold a bank of NUM_CH signed DATA_WIDTH partial-sum registers, sum_q[0..NUM_CH-1].
REQ-016 SHALL drive ov_sum = sum_q[iv_ch] combinationally; an iv_ch value >= NUM_CH SHALL read 0.
REQ-017 SHALL form the full product p = iv_din * iv_weight at 2*DATA_WIDTH signed bits.
REQ-018 SHALL scale the product as ps = p >>> (DATA_WIDTH-1) when ROUND=0, and as ps = (p + 2^(DATA_WIDTH-2)) >>> (DATA_WIDTH-1) when ROUND=1.
REQ-019 SHALL hold ps at DATA_WIDTH+2 bits without loss.
REQ-020 SHALL compute s = ps' + iv_sum at DATA_WIDTH+2 bits, where ps' is ps limited per REQ-031/REQ-032.
REQ-021 SHALL write sum_q[iv_ch] <= result(s) on a rising edge with i_en=1, i_valid=1 and iv_ch < NUM_CH; all other channels hold.
REQ-022 SHALL have a latency of 1 cycle: the next read of ov_sum for the same channel returns the updated value.
REQ-023 SHALL discard an i_valid with iv_ch >= NUM_CH, with no state change.
REQ-024 SHALL set o_prod_ovf when a write cycle per REQ-021 has ps outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-025 SHALL set o_sum_ovf when a write cycle per REQ-021 has s outside the same range.
REQ-026 SHALL keep both flags set until reset or i_clr_flags.
REQ-027 SHALL clear every sum_q to 0 when i_flush=1 and i_en=1; i_flush has priority over a simultaneous write, and that sample is dropped.
REQ-028 SHALL give precedence to a new overflow over i_clr_flags in the same cycle; the flag stays 1.
REQ-029 SHALL ignore i_flush and i_clr_flags when i_en=0.

Reset
REQ-030 SHALL, on i_rst_n=0 at any time, mid-stream included, asynchronously clear every sum_q, o_prod_ovf and o_sum_ovf to 0 (so ov_sum reads 0); operation resumes on the first rising edge after release.

Configuration
REQ-031 SHALL, when macro TAP_TRANSPOSED_SAT_EN is defined, clamp ps to the DATA_WIDTH range before the add and clamp s to the range (max 2^(DATA_WIDTH-1)-1, min -2^(DATA_WIDTH-1)) before storage.
REQ-032 SHALL, when TAP_TRANSPOSED_SAT_EN is undefined, use ps' = ps[DATA_WIDTH-1:0] and store s[DATA_WIDTH-1:0], i.e. two's-complement wrap; the flags SHALL still report per REQ-024/REQ-025.

Verification (DATA_WIDTH=8, NUM_CH=4)
REQ-033 Bench SHALL cover: ROUND=0, ch0: din=0x40, w=0x40, sum=0x00 -> next ov_sum(ch0)=0x20, flags 0.
REQ-034 Bench SHALL cover: din=0x80, w=0x80, sum=0x00 -> with SAT_EN, ov_sum=0x7F and o_prod_ovf=1; without SAT_EN, ov_sum=0x80 and o_prod_ovf=1.
REQ-035 Bench SHALL cover: din=0x60, w=0x7F, sum=0x60 -> with SAT_EN, ov_sum=0x7F and o_sum_ovf=1; without SAT_EN, the wrapped value and o_sum_ovf=1.
REQ-036 Bench SHALL cover: din=0x01, w=0x40 -> ROUND=0 gives ov_sum=0x00; ROUND=1 gives 0x01.
REQ-037 Bench SHALL cover: interleaved writes ch0=0x10, ch1=0x20, ch3=0x30, then iv_ch swept 0..3 -> 0x10, 0x20, 0x00, 0x30.
REQ-038 Bench SHALL cover: i_flush together with a valid write, then i_rst_n pulsed low mid-stream -> all channels read 0, flags 0; the subsequent write lands correctly.
